// File: rtl/sliding_window_gen_pkg.sv
// Shared geometry defaults and window-layout helpers for the sliding window
// generator and the conv core unpacker.
package sliding_window_gen_pkg;

    localparam int DEF_BIT_WIDTH   = 8;
    localparam int DEF_NUM_CHANNEL = 3;
    localparam int DEF_IMG_WIDTH   = 8;
    localparam int DEF_IMG_HEIGHT  = 8;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_PIX_W       = DEF_BIT_WIDTH * DEF_NUM_CHANNEL;

    function automatic int pix_w(input int bit_width, input int num_channel);
        return bit_width * num_channel;
    endfunction

    // Flat element index of window position (r,c); r=0 is the top row.
    function automatic int win_idx(input int r, input int c, input int kernel_size);
        return r * kernel_size + c;
    endfunction

endpackage

// File: rtl/sliding_window_gen_if.sv
// Pixel-in / window-out valid/rdy streams of the sliding window generator.
interface sliding_window_gen_if
    import sliding_window_gen_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int NUM_CHANNEL = DEF_NUM_CHANNEL,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
);
    localparam int PIX_W = pix_w(BIT_WIDTH, NUM_CHANNEL);
    localparam int WIN_W = KERNEL_SIZE * KERNEL_SIZE * PIX_W;

    logic             prev_layer_valid;
    logic             prev_layer_rdy;
    logic [PIX_W-1:0] prev_layer_data;
    logic             next_layer_valid;
    logic             next_layer_rdy;
    logic [WIN_W-1:0] next_layer_data;

    modport slave (
        input  prev_layer_valid, prev_layer_data, next_layer_rdy,
        output prev_layer_rdy, next_layer_valid, next_layer_data
    );

    modport master (
        output prev_layer_valid, prev_layer_data, next_layer_rdy,
        input  prev_layer_rdy, next_layer_valid, next_layer_data
    );

endinterface

// File: rtl/sliding_window_gen_line_buffer.sv
// One-row delay line: dout is the pixel shifted in DEPTH shifts earlier.
module line_buffer #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 shift_en,
    input  logic [BIT_WIDTH-1:0] din,
    output logic [BIT_WIDTH-1:0] dout
);
    // Contents are left unreset; the top level never exposes stale entries.
    logic [DEPTH-1:0][BIT_WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (shift_en) sr <= {sr[DEPTH-2:0], din};
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/sliding_window_gen.sv
// Streaming KxK window generator (stride 1, no padding) over raster-order
// multi-channel pixels, with K-1 line buffers and a single output slot.
module sliding_window_gen
    import sliding_window_gen_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int NUM_CHANNEL = DEF_NUM_CHANNEL,
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input logic               clk,
    input logic               rst,
    sliding_window_gen_if.slave bus
);
    localparam int PIX_W = pix_w(BIT_WIDTH, NUM_CHANNEL);
    localparam int K     = KERNEL_SIZE;
    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);

    logic acc, snd, out_vld, col_last, row_last, win_done;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    logic [K-1:0][K-1:0][PIX_W-1:0] win;
    logic [K-2:0][PIX_W-1:0]        lb_din, lb_dout;
    logic [K-1:0][PIX_W-1:0]        new_col;

    assign bus.prev_layer_rdy   = !out_vld || bus.next_layer_rdy;
    assign bus.next_layer_valid = out_vld;
    assign acc = bus.prev_layer_valid && bus.prev_layer_rdy;
    assign snd = out_vld && bus.next_layer_rdy;

    assign col_last = (col_cnt == CW'(IMG_WIDTH - 1));
    assign row_last = (row_cnt == RW'(IMG_HEIGHT - 1));
    // Pixel being accepted is the bottom-right corner of a full in-frame window.
    assign win_done = (row_cnt >= RW'(K - 1)) && (col_cnt >= CW'(K - 1));

    // Buffer k feeds buffer k+1, so buffer k holds the row k+1 above.
    always_comb begin
        lb_din    = '0;
        lb_din[0] = bus.prev_layer_data;
        for (int k = 1; k < K - 1; k++) lb_din[k] = lb_dout[k-1];
        new_col      = '0;
        new_col[K-1] = bus.prev_layer_data;
        for (int r = 0; r < K - 1; r++) new_col[r] = lb_dout[K-2-r];
    end

    for (genvar k = 0; k < K - 1; k++) begin : g_lb
        line_buffer #(.BIT_WIDTH(PIX_W), .DEPTH(IMG_WIDTH)) u_lb (
            .clk     (clk),
            .shift_en(acc),
            .din     (lb_din[k]),
            .dout    (lb_dout[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (acc) begin
            col_cnt <= col_last ? '0 : col_cnt + CW'(1);
            if (col_last) row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '0;
        end else if (acc) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
                win[r][K-1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  out_vld <= 1'b0;
        else if (acc && win_done) out_vld <= 1'b1;
        else if (snd)             out_vld <= 1'b0;
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign bus.next_layer_data[win_idx(r, c, K)*PIX_W +: PIX_W] = win[r][c];
        end
    end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed bench for sliding_window_gen at K=3, 4x4 frame, one 8-bit channel.
module tb_sliding_window_gen;
    localparam int BW = 8, NC = 1, W = 4, H = 4, K = 3;
    localparam int WIN_W = K * K * BW * NC;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    logic rnd_mode = 1'b0;
    logic rdy_hold = 1'b1;
    logic [WIN_W-1:0] got[$];
    int   tops[4] = '{0, 1, 4, 5};

    always #5 clk = ~clk;

    sliding_window_gen_if #(.BIT_WIDTH(BW), .NUM_CHANNEL(NC), .KERNEL_SIZE(K)) bus ();

    sliding_window_gen #(
        .BIT_WIDTH(BW), .NUM_CHANNEL(NC), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Downstream ready: sole driver, updated 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        bus.next_layer_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_hold;
    end

    always @(negedge clk) begin
        if (!rst && bus.next_layer_valid && bus.next_layer_rdy) got.push_back(bus.next_layer_data);
    end

    task automatic check(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Window with top-left pixel value base+top, pixel value = base + row*W + col.
    function automatic logic [WIN_W-1:0] exp_win(input int base, input int top);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*BW +: BW] = 8'(base + top + r*W + c);
        return w;
    endfunction

    task automatic send_px(input int v);
        int n;
        bus.prev_layer_valid = 1'b1;
        bus.prev_layer_data  = 8'(v);
        n = 0;
        @(negedge clk);
        while (!bus.prev_layer_rdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.prev_layer_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int i = 0; i < W * H; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (gaps) #1;
            send_px(base + i);
        end
    endtask

    task automatic check_frames(input string tag, input int base0, input int nframes, input int base1);
        check({tag, "_count"}, WIN_W'(got.size()), WIN_W'(4 * nframes));
        for (int i = 0; i < got.size() && i < 4 * nframes; i++)
            check(tag, got[i], exp_win(i < 4 ? base0 : base1, tops[i % 4]));
    endtask

    initial begin
        void'($urandom(32'd7));
        rst = 1'b1;
        bus.prev_layer_valid = 1'b0;
        bus.prev_layer_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", WIN_W'(bus.next_layer_valid), 0);
        check("rst_data", bus.next_layer_data, 0);
        check("rst_rdy", WIN_W'(bus.prev_layer_rdy), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full rate: valid expected exactly after pixels 10, 11, 14, 15.
        got.delete();
        for (int i = 0; i < W * H; i++) begin
            send_px(i);
            check("fr_rdy", WIN_W'(bus.prev_layer_rdy), 1);
            check("fr_valid", WIN_W'(bus.next_layer_valid),
                  WIN_W'(i == 10 || i == 11 || i == 14 || i == 15));
            if (i == 10 || i == 11 || i == 14 || i == 15)
                check("fr_data", bus.next_layer_data, exp_win(0, i - 10));
        end
        repeat (2) @(posedge clk);
        #1;
        check_frames("fr_seq", 0, 1, 0);

        // Backpressure while the first window is held.
        got.delete();
        for (int i = 0; i <= 10; i++) send_px(i);
        rdy_hold = 1'b0;
        bus.prev_layer_valid = 1'b1;
        bus.prev_layer_data  = 8'd11;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("bp_rdy", WIN_W'(bus.prev_layer_rdy), 0);
            check("bp_valid", WIN_W'(bus.next_layer_valid), 1);
            check("bp_data", bus.next_layer_data, exp_win(0, 0));
        end
        rdy_hold = 1'b1;
        for (int i = 11; i < W * H; i++) send_px(i);
        repeat (3) @(posedge clk);
        #1;
        check_frames("bp_seq", 0, 1, 0);

        // Random upstream gaps and downstream stalls.
        got.delete();
        rnd_mode = 1'b1;
        send_frame(0, 1'b1);
        rnd_mode = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_frames("rnd_seq", 0, 1, 0);

        // Two frames back to back; second offset by 100.
        got.delete();
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_frames("b2b_seq", 0, 2, 100);

        // Reset mid-frame, then a fresh frame with values offset by 50.
        got.delete();
        for (int i = 0; i < 6; i++) send_px(i);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_valid", WIN_W'(bus.next_layer_valid), 0);
        check("mrst_data", bus.next_layer_data, 0);
        check("mrst_rdy", WIN_W'(bus.prev_layer_rdy), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(50, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_frames("mrst_seq", 50, 1, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/sliding_window_gen.md
# sliding_window_gen

Streaming sliding-window generator that sits directly downstream of a channel buffer stage in the conv datapath. It consumes one multi-channel pixel per handshake in raster order and emits one KERNEL_SIZE×KERNEL_SIZE window per valid convolution position (stride 1, no padding) to the convolution core. Row history is held in KERNEL_SIZE-1 line buffers. Both ports use the same valid/rdy handshake as the rest of the pipeline.

## Interface
- BIT_WIDTH, 8: bits per channel sample
- NUM_CHANNEL, 3: channels per pixel
- IMG_WIDTH, 8: pixels per row, ≥ KERNEL_SIZE
- IMG_HEIGHT, 8: rows per frame, ≥ KERNEL_SIZE
- KERNEL_SIZE, 3: window side, ≥ 2
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- prev_layer_valid  in  1  upstream pixel valid
- prev_layer_rdy  out  1  block accepts a pixel this cycle
- prev_layer_data  in  NUM_CHANNEL*BIT_WIDTH  pixel; channel c at bits [c*BIT_WIDTH +: BIT_WIDTH]
- next_layer_rdy  in  1  downstream ready
- next_layer_valid  out  1  window valid
- next_layer_data  out  KERNEL_SIZE*KERNEL_SIZE*NUM_CHANNEL*BIT_WIDTH  window; element (r,c) at index r*KERNEL_SIZE+c, each element one pixel wide; r=0 is the oldest (top) row; c=0 is the leftmost (oldest) column

## Operation
- Accept: acc = prev_layer_valid && prev_layer_rdy. Send: snd = next_layer_valid && next_layer_rdy.
- prev_layer_rdy = !next_layer_valid || next_layer_rdy. This is combinational and gives full throughput with a single output slot.
- Counters col_cnt (0..IMG_WIDTH-1) and row_cnt (0..IMG_HEIGHT-1) give the position of the next pixel to accept.
  - On acc, col_cnt increments. At IMG_WIDTH-1 it wraps to 0 and row_cnt increments.
  - row_cnt wraps to 0 after IMG_HEIGHT-1, which ends the frame.
  - The next frame follows with no bubble.
- Line buffers:
  - On acc, line buffer 0 shifts in the pixel. Line buffer k shifts in the output of buffer k-1.
  - Each buffer is an IMG_WIDTH-deep delay, so buffer k outputs the pixel from k+1 rows above.
- Window registers:
  - On acc, every window row shifts left by one column.
  - The new rightmost column is {buffer K-2 out, …, buffer 0 out, incoming pixel}, ordered top to bottom.
- Output valid:
  - On acc at position (row_cnt ≥ K-1, col_cnt ≥ K-1), next_layer_valid is set at the next edge.
  - Otherwise it is cleared when snd occurs without a completing accept.
  - A window is emitted only when all KERNEL_SIZE rows and columns belong to the current frame row range. Windows never straddle a row boundary or a frame boundary.
- Simultaneous snd and acc: the old window leaves and the new one loads in the same edge, with no bubble.
- next_layer_data is driven directly by the window registers and is held stable while valid && !rdy. No accept occurs while stalled, so the window cannot shift.
- Windows per frame: (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1).

## Timing
- Latency: window valid 1 cycle after the accept of its bottom-right pixel.
- Throughput: 1 pixel/cycle sustained when next_layer_rdy is held high.
- Reset values:
  - next_layer_valid = 0
  - prev_layer_rdy = 1
  - next_layer_data = 0 (window registers reset to 0)
  - counters = 0
- Line buffer contents are not reset; garbage is never exposed because of the row/col gating.
- Reset mid-frame: any pending window is dropped, and the next accepted pixel is treated as (0,0).
- prev_layer_valid with no accept: no state change.

## Structure
- Shared package holds:
  - the window element index helper (r*KERNEL_SIZE+c) and per-pixel width localparam, also used by the conv core unpacker;
  - default geometry constants.
- Sub-module line_buffer (parameters BIT_WIDTH, DEPTH; ports clk, shift_en, din, dout): a shift-register delay. K-1 instances are generated.
- Top level: counters, window register array, output valid register, handshake logic.

## Test plan
All scenarios use K=3, W=4, H=4, NUM_CHANNEL=1, BIT_WIDTH=8. Pixel value = row*4+col.
1. Full-rate frame with both valid and rdy always high -> exactly 4 windows:
   - {0,1,2,4,5,6,8,9,10}, appearing 1 cycle after accepting pixel 10;
   - then tops 1, 4, 5;
   - prev_layer_rdy never drops.
2. Backpressure: next_layer_rdy low for 5 cycles while window 1 is valid -> prev_layer_rdy=0, data stable at {0,1,2,4,5,6,8,9,10}, no pixel lost; sequence then continues unchanged.
3. Random upstream valid gaps and downstream rdy gaps (seeded) -> window sequence identical to scenario 1 and per-frame count = 4.
4. Two back-to-back frames (second frame values +100) -> second frame's first window {100,101,102,104,105,106,108,109,110}; no window mixes frames.
5. Reset asserted after 6 pixels, then a fresh frame -> no window emitted before the new pixel 10; outputs read 0/0/1 (next_layer_valid, next_layer_data, prev_layer_rdy) during reset.
6. Row-boundary check: no window with top-left column 2 or 3 (e.g. {2,3,4,…}) is ever produced.
